// File: rtl/mem_block_copier.sv
// Block-copy DMA engine: streams a byte range from src to dst one beat per cycle
// through a synchronous-read port and a byte-masked write port.
module mem_block_copier #(
  parameter  int NUM_BYTES  = 2097152,
  parameter  int DATA_WIDTH = 64,
  localparam int ADDR_WIDTH = $clog2(NUM_BYTES),
  localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [MASK_WIDTH-1:0] wr_mask,
  output logic                  wr_en
);

  localparam int LEN_W  = ADDR_WIDTH + 1;
  localparam int OFF_W  = $clog2(MASK_WIDTH);
  localparam int BEAT_W = LEN_W - OFF_W;
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(MASK_WIDTH);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FIN, REJ} state_t;

  state_t                state;
  logic [BEAT_W-1:0]     rd_left;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [MASK_WIDTH-1:0] last_mask;

  logic                  misaligned;
  logic                  too_long;
  logic [LEN_W-1:0]      len_m1;
  logic [MASK_WIDTH-1:0] tail_mask;

  assign misaligned = (cmd_src[OFF_W-1:0] != '0) || (cmd_dst[OFF_W-1:0] != '0);
  assign too_long   = cmd_len > LEN_W'(NUM_BYTES);
  assign len_m1     = cmd_len - LEN_W'(1);
  assign tail_mask  = (cmd_len[OFF_W-1:0] == '0) ? '1 :
                      MASK_WIDTH'((32'd1 << cmd_len[OFF_W-1:0]) - 32'd1);

  // Write data is the read beat returned this cycle, forced to zero outside write cycles.
  assign wr_data = wr_en ? rd_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_mask   <= '0;
      wr_en     <= 1'b0;
      rd_left   <= '0;
      wr_ptr    <= '0;
      last_mask <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (misaligned || too_long) begin
              state <= REJ;
              err   <= 1'b1;
            end else if (cmd_len == '0) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              rd_addr   <= cmd_src;
              wr_ptr    <= cmd_dst;
              rd_left   <= BEAT_W'(len_m1 >> OFF_W);
              last_mask <= tail_mask;
            end
          end
        end
        // Each RUN cycle issues one read and schedules the write of the beat read last cycle.
        RUN: begin
          wr_en   <= 1'b1;
          wr_addr <= wr_ptr;
          wr_ptr  <= wr_ptr + STRIDE;
          if (rd_left == '0) begin
            wr_mask <= last_mask;
            state   <= DRAIN;
          end else begin
            wr_mask <= '1;
            rd_addr <= rd_addr + STRIDE;
            rd_left <= rd_left - BEAT_W'(1);
          end
        end
        DRAIN: begin
          wr_en   <= 1'b0;
          wr_addr <= '0;
          wr_mask <= '0;
          done    <= 1'b1;
          state   <= FIN;
        end
        FIN: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        REJ: begin
          err       <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_copier.sv
// Bench for mem_block_copier: byte-addressed write-first memory, a byte-level
// forward-copy reference model, and directed plus randomised copy requests.
module tb_mem_block_copier;

  localparam int NUM_BYTES = 2097152;
  localparam int AW        = $clog2(NUM_BYTES);
  localparam int DW        = 64;
  localparam int MW        = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [AW:0]   cmd_len;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] wr_mask;
  logic          wr_en;

  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  bit [7:0] mem     [NUM_BYTES];
  bit [7:0] ref_mem [NUM_BYTES];

  int checks = 0;
  int errors = 0;

  mem_block_copier #(.NUM_BYTES(NUM_BYTES), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .wr_en     (wr_en)
  );

  always #5 clk = ~clk;

  // Shared memory: a write and a read of the same beat in one cycle returns the new bytes.
  always @(posedge clk) begin
    for (int i = 0; i < MW; i++) begin
      if (pl_en)
        mem[int'(pl_addr) + i] <= pl_data[i*8 +: 8];
      else if (wr_en && wr_mask[i])
        mem[int'(wr_addr) + i] <= wr_data[i*8 +: 8];
      if (wr_en && wr_mask[i] && wr_addr == rd_addr)
        rd_data[i*8 +: 8] <= wr_data[i*8 +: 8];
      else
        rd_data[i*8 +: 8] <= mem[int'(rd_addr) + i];
    end
  end

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic preload_beat(input int unsigned addr, input logic [63:0] data);
    int unsigned a;
    a = addr % NUM_BYTES;
    pl_en   = 1'b1;
    pl_addr = AW'(a);
    pl_data = data;
    for (int j = 0; j < MW; j++) ref_mem[(a + j) % NUM_BYTES] = data[j*8 +: 8];
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic preload_random(input int unsigned addr, input int nbeats);
    for (int b = 0; b < nbeats; b++)
      preload_beat(addr + 8 * b, {$urandom, $urandom});
  endtask

  // Reference: byte-by-byte ascending copy, each byte read after all earlier bytes landed.
  task automatic ref_copy(input int unsigned src, input int unsigned dst, input int unsigned len);
    for (int unsigned i = 0; i < len; i++)
      ref_mem[(dst + i) % NUM_BYTES] = ref_mem[(src + i) % NUM_BYTES];
  endtask

  task automatic compare_window(input string tag, input int unsigned start, input int unsigned nbytes);
    int unsigned a;
    for (int unsigned i = 0; i < nbytes; i++) begin
      a = (start + i) % NUM_BYTES;
      check_output($sformatf("%s_mem_%0h", tag, a), 64'(mem[a]), 64'(ref_mem[a]));
    end
  endtask

  // Issues one request and checks every port, cycle by cycle, until cmd_ready returns.
  task automatic apply_stimulus(input string tag, input int unsigned src,
                                input int unsigned dst, input int unsigned len);
    bit          rej;
    bit          moves;
    bit          we;
    int          n;
    int          done_c;
    int          err_c;
    int          ready_c;
    int          k;
    logic [7:0]  last_mask;

    rej       = (src % MW != 0) || (dst % MW != 0) || (len > NUM_BYTES);
    moves     = !rej && (len != 0);
    n         = int'((len + MW - 1) / MW);
    last_mask = (len % MW == 0) ? 8'hFF : 8'((1 << (len % MW)) - 1);
    done_c    = rej ? -1 : (moves ? n + 2 : 1);
    err_c     = rej ? 1 : -1;
    ready_c   = moves ? n + 3 : 2;

    check_output({tag, "_ready_idle"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_src   = AW'(src);
    cmd_dst   = AW'(dst);
    cmd_len   = (AW+1)'(len);
    @(negedge clk);

    for (int c = 1; c <= ready_c; c++) begin
      we = moves && (c >= 2) && (c <= n + 1);
      check_output($sformatf("%s_c%0d_done", tag, c), 64'(done), 64'(c == done_c));
      check_output($sformatf("%s_c%0d_err", tag, c), 64'(err), 64'(c == err_c));
      check_output($sformatf("%s_c%0d_ready", tag, c), 64'(cmd_ready), 64'(c == ready_c));
      check_output($sformatf("%s_c%0d_busy", tag, c), 64'(busy), 64'(!rej && c < ready_c));
      check_output($sformatf("%s_c%0d_wr_en", tag, c), 64'(wr_en), 64'(we));
      if (we) begin
        k = c - 2;
        check_output($sformatf("%s_c%0d_wr_addr", tag, c), 64'(wr_addr),
                     64'((dst + 8 * k) % NUM_BYTES));
        check_output($sformatf("%s_c%0d_wr_mask", tag, c), 64'(wr_mask),
                     64'((k == n - 1) ? last_mask : 8'hFF));
      end else begin
        check_output($sformatf("%s_c%0d_wr_addr0", tag, c), 64'(wr_addr), 64'(0));
        check_output($sformatf("%s_c%0d_wr_mask0", tag, c), 64'(wr_mask), 64'(0));
        check_output($sformatf("%s_c%0d_wr_data0", tag, c), 64'(wr_data), 64'(0));
      end
      if (moves && c <= n)
        check_output($sformatf("%s_c%0d_rd_addr", tag, c), 64'(rd_addr),
                     64'((src + 8 * (c - 1)) % NUM_BYTES));
      if (c < ready_c) begin
        // Junk requests while the engine is occupied must be ignored.
        cmd_valid = 1'b1;
        cmd_src   = AW'($urandom);
        cmd_dst   = AW'($urandom);
        cmd_len   = (AW+1)'($urandom_range(0, 64));
        @(negedge clk);
      end else begin
        cmd_valid = 1'b0;
      end
    end

    if (moves) ref_copy(src, dst, len);
    compare_window(tag, dst + NUM_BYTES - 8, ((len > 64) ? 64 : len) + 16);
  endtask

  initial begin
    logic [63:0]  d;
    int unsigned  src;
    int unsigned  dst;
    int unsigned  len;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
    repeat (3) @(negedge clk);

    check_output("reset_ready", 64'(cmd_ready), 64'(1));
    check_output("reset_busy", 64'(busy), 64'(0));
    check_output("reset_done", 64'(done), 64'(0));
    check_output("reset_err", 64'(err), 64'(0));
    check_output("reset_wr_en", 64'(wr_en), 64'(0));
    check_output("reset_rd_addr", 64'(rd_addr), 64'(0));
    check_output("reset_wr_addr", 64'(wr_addr), 64'(0));
    check_output("reset_wr_mask", 64'(wr_mask), 64'(0));
    check_output("reset_wr_data", 64'(wr_data), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] aligned 4-beat copy");
    preload_random(32'h1FF8, 6);
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'(b * 8 + j);
      preload_beat(32'h100 + 8 * b, d);
    end
    apply_stimulus("copy32", 32'h100, 32'h2000, 32);
    for (int i = 0; i < 32; i++)
      check_output($sformatf("copy32_byte%0d", i), 64'(mem[32'h2000 + i]), 64'(i));

    $display("[TB] partial last beat");
    preload_random(32'h40, 2);
    preload_random(32'h78, 4);
    apply_stimulus("len13", 32'h40, 32'h80, 13);

    $display("[TB] rejects and empty copy");
    apply_stimulus("misaligned", 32'h103, 32'h2000, 8);
    apply_stimulus("dst_misaligned", 32'h100, 32'h2004, 8);
    apply_stimulus("too_long", 32'h100, 32'h2000, NUM_BYTES + 1);
    apply_stimulus("len0", 32'h100, 32'h2000, 0);

    $display("[TB] wrap past top of memory");
    preload_random(NUM_BYTES - 8, 1);
    preload_random(0, 1);
    preload_random(32'h3FF8, 4);
    apply_stimulus("wrap_src", NUM_BYTES - 8, 32'h4000, 16);
    preload_random(32'h5000, 2);
    preload_random(NUM_BYTES - 16, 4);
    apply_stimulus("wrap_dst", 32'h5000, NUM_BYTES - 8, 16);

    $display("[TB] overlapping forward copy");
    preload_beat(0, {8{8'hA5}});
    preload_random(8, 4);
    apply_stimulus("overlap", 0, 8, 24);
    for (int i = 8; i < 32; i++)
      check_output($sformatf("overlap_byte%0d", i), 64'(mem[i]), 64'(8'hA5));

    $display("[TB] reset during copy");
    preload_random(32'h300, 4);
    preload_random(32'h5F8, 6);
    cmd_valid = 1'b1;
    cmd_src   = AW'(32'h300);
    cmd_dst   = AW'(32'h600);
    cmd_len   = (AW+1)'(32);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("rst_mid_wr_en_before", 64'(wr_en), 64'(1));
    rst_n = 1'b0;
    #1;
    check_output("rst_mid_wr_en", 64'(wr_en), 64'(0));
    check_output("rst_mid_ready", 64'(cmd_ready), 64'(1));
    check_output("rst_mid_busy", 64'(busy), 64'(0));
    check_output("rst_mid_wr_mask", 64'(wr_mask), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output($sformatf("rst_hold%0d_done", i), 64'(done), 64'(0));
      check_output($sformatf("rst_hold%0d_wr_en", i), 64'(wr_en), 64'(0));
    end
    rst_n = 1'b1;
    ref_copy(32'h300, 32'h600, 8);
    compare_window("rst_partial", 32'h5F8, 48);
    @(negedge clk);
    apply_stimulus("post_rst", 32'h300, 32'h600, 32);

    $display("[TB] randomised copies");
    for (int t = 0; t < 8; t++) begin
      src = $urandom_range(0, NUM_BYTES / 8 - 1) * 8;
      if (t % 2 == 1)
        dst = (src + 8 * $urandom_range(0, 4)) % NUM_BYTES;
      else
        dst = $urandom_range(0, NUM_BYTES / 8 - 1) * 8;
      len = $urandom_range(1, 64);
      preload_random(src, int'((len + 7) / 8));
      preload_random(dst + NUM_BYTES - 8, int'((len + 7) / 8) + 2);
      apply_stimulus($sformatf("rand%0d", t), src, dst, len);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
